// File: rtl/banked_reg_file.sv
// banked_reg_file
//   Multi-bank register file with a background bank-to-bank copy engine.
//   The active bank (Bank_Sel) serves five combinational read ports and one
//   user write port. The halt register of the active bank is reloaded from
//   Counter_Halt on every clock edge. A copy FSM (IDLE -> COPY -> DONE)
//   moves one register per cycle from a latched source bank to a latched
//   destination bank; user and halt writes win over a colliding copy write.
//
// Ports
//   Clock          rising-edge clock
//   Reset          asynchronous active-low reset
//   Reg_Write      write enable for the active bank
//   Reg_escrita    write index (also read back on Rd)
//   Reg_dados      write data
//   Reg_1, Reg_2   read indices for Rs, Rt
//   Counter_Halt   value loaded into HALT_REG of the active bank each cycle
//   Bank_Sel       active bank
//   Copy_Start     request a copy from Copy_Src to Copy_Dst
//   Copy_Src/Dst   source / destination bank of a copy
//   Rs, Rt, Rd     reads of Reg_1, Reg_2, Reg_escrita
//   Rpc, Rspc      reads of PC_REG, SPC_REG
//   Copy_Busy      high while registers are being copied
//   Copy_Done      one-cycle pulse after the last register is copied
module banked_reg_file #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int NUM_BANKS   = 2,
  parameter int HALT_REG    = 24,
  parameter int PC_REG      = 25,
  parameter int SPC_REG     = 26,
  parameter int ZERO_REG_EN = 1,
  parameter int BYPASS_EN   = 0,
  localparam int BANK_W     = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Reg_Write,
  input  logic [ADDR_W-1:0] Reg_escrita,
  input  logic [DATA_W-1:0] Reg_dados,
  input  logic [ADDR_W-1:0] Reg_1,
  input  logic [ADDR_W-1:0] Reg_2,
  input  logic [DATA_W-1:0] Counter_Halt,
  input  logic [BANK_W-1:0] Bank_Sel,
  input  logic              Copy_Start,
  input  logic [BANK_W-1:0] Copy_Src,
  input  logic [BANK_W-1:0] Copy_Dst,
  output logic [DATA_W-1:0] Rs,
  output logic [DATA_W-1:0] Rt,
  output logic [DATA_W-1:0] Rd,
  output logic [DATA_W-1:0] Rpc,
  output logic [DATA_W-1:0] Rspc,
  output logic              Copy_Busy,
  output logic              Copy_Done
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [BANK_W:0]   NB       = (BANK_W + 1)'(NUM_BANKS);
  localparam logic [ADDR_W-1:0] HALT_IDX = ADDR_W'(HALT_REG);
  localparam logic [ADDR_W-1:0] PC_IDX   = ADDR_W'(PC_REG);
  localparam logic [ADDR_W-1:0] SPC_IDX  = ADDR_W'(SPC_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [BANK_W-1:0]   src_q, src_d;
  logic [BANK_W-1:0]   dst_q, dst_d;
  logic                copy_we;
  logic [DATA_W-1:0]   copy_data;

  logic [DATA_W-1:0]   regs_q [NUM_BANKS][DEPTH];
  logic [DATA_W-1:0]   act    [DEPTH];

  logic bank_ok;
  logic start_ok;

  // Bank numbers are compared one bit wider so a non-power-of-two bank
  // count still rejects the unused encodings.
  assign bank_ok  = ({1'b0, Bank_Sel} < NB);
  assign start_ok = Copy_Start && ({1'b0, Copy_Src} < NB) && ({1'b0, Copy_Dst} < NB);

  function automatic logic [DATA_W-1:0] mask_zero(input logic [ADDR_W-1:0] idx,
                                                  input logic [DATA_W-1:0] val);
    return ((ZERO_REG_EN != 0) && (idx == '0)) ? '0 : val;
  endfunction

  function automatic logic can_bypass(input logic [ADDR_W-1:0] idx);
    return (BYPASS_EN != 0) && Reg_Write && bank_ok && (idx == Reg_escrita) &&
           (idx != HALT_IDX) && !((ZERO_REG_EN != 0) && (idx == '0));
  endfunction

  // View of the active bank; an out-of-range bank reads as all zeros.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      act[i] = bank_ok ? regs_q[Bank_Sel][i] : '0;
    end
  end

  always_comb begin
    Rs   = can_bypass(Reg_1) ? Reg_dados : mask_zero(Reg_1, act[Reg_1]);
    Rt   = can_bypass(Reg_2) ? Reg_dados : mask_zero(Reg_2, act[Reg_2]);
    Rd   = mask_zero(Reg_escrita, act[Reg_escrita]);
    Rpc  = mask_zero(PC_IDX, act[PC_IDX]);
    Rspc = mask_zero(SPC_IDX, act[SPC_IDX]);
  end

  // Source word read in the copy cycle itself, so earlier copy writes of
  // the same run are visible when source and destination overlap.
  assign copy_data = regs_q[src_q][idx_q];

  // Copy FSM next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    dst_d   = dst_q;
    copy_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_COPY;
          idx_d   = '0;
          src_d   = Copy_Src;
          dst_d   = Copy_Dst;
        end
      end
      S_COPY: begin
        copy_we = 1'b1;
        idx_d   = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Copy_Busy = (state_q == S_COPY);
  assign Copy_Done = (state_q == S_DONE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  // Register storage. Later assignments override earlier ones, giving the
  // priority halt > user > copy, with register 0 pinned last.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          regs_q[b][i] <= '0;
        end
      end
    end else begin
      if (copy_we) begin
        regs_q[dst_q][idx_q] <= copy_data;
      end
      if (Reg_Write && bank_ok) begin
        regs_q[Bank_Sel][Reg_escrita] <= Reg_dados;
      end
      if (bank_ok) begin
        regs_q[Bank_Sel][HALT_IDX] <= Counter_Halt;
      end
      if (ZERO_REG_EN != 0) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          regs_q[b][0] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_banked_reg_file.sv
// Directed bench for banked_reg_file with a bank-array reference model.
module tb_banked_reg_file;

  localparam int NB    = 2;
  localparam int DEPTH = 32;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Reg_Write;
  logic [4:0]  Reg_escrita, Reg_1, Reg_2;
  logic [31:0] Reg_dados, Counter_Halt;
  logic        Bank_Sel, Copy_Start, Copy_Src, Copy_Dst;
  logic [31:0] Rs, Rt, Rd, Rpc, Rspc;
  logic        Copy_Busy, Copy_Done;

  // Second instance with three banks so an out-of-range bank is encodable.
  logic        c3_start;
  logic [1:0]  c3_src, c3_dst, c3_sel;
  logic [31:0] Rs3, Rt3, Rd3, Rpc3, Rspc3;
  logic        Busy3, Done3;

  always #5 Clock = ~Clock;

  banked_reg_file dut (
    .Clock(Clock), .Reset(Reset), .Reg_Write(Reg_Write), .Reg_escrita(Reg_escrita),
    .Reg_dados(Reg_dados), .Reg_1(Reg_1), .Reg_2(Reg_2), .Counter_Halt(Counter_Halt),
    .Bank_Sel(Bank_Sel), .Copy_Start(Copy_Start), .Copy_Src(Copy_Src), .Copy_Dst(Copy_Dst),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .Rpc(Rpc), .Rspc(Rspc),
    .Copy_Busy(Copy_Busy), .Copy_Done(Copy_Done)
  );

  banked_reg_file #(.NUM_BANKS(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .Reg_Write(Reg_Write), .Reg_escrita(Reg_escrita),
    .Reg_dados(Reg_dados), .Reg_1(Reg_1), .Reg_2(Reg_2), .Counter_Halt(Counter_Halt),
    .Bank_Sel(c3_sel), .Copy_Start(c3_start), .Copy_Src(c3_src), .Copy_Dst(c3_dst),
    .Rs(Rs3), .Rt(Rt3), .Rd(Rd3), .Rpc(Rpc3), .Rspc(Rspc3),
    .Copy_Busy(Busy3), .Copy_Done(Done3)
  );

  integer nvec = 0;
  integer nerr = 0;
  bit     chk_en = 1'b0;

  // Reference model: plain arrays plus "copy in progress at register k".
  logic [31:0] mem [NB][DEPTH];
  bit          m_copy, m_done;
  int          m_k, m_src, m_dst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input int b, input int idx);
    if (idx == 0) return 32'h0;
    return mem[b][idx];
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int b = 0; b < NB; b++)
        for (int i = 0; i < DEPTH; i++) mem[b][i] = 32'h0;
      m_copy = 1'b0;
      m_done = 1'b0;
      m_k    = 0;
    end else begin
      if (m_copy) mem[m_dst][m_k] = mem[m_src][m_k];
      if (Reg_Write) mem[Bank_Sel][Reg_escrita] = Reg_dados;
      mem[Bank_Sel][24] = Counter_Halt;
      mem[0][0] = 32'h0;
      mem[1][0] = 32'h0;
      if (m_copy) begin
        if (m_k == DEPTH - 1) begin
          m_copy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_k++;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (Copy_Start) begin
        m_copy = 1'b1;
        m_k    = 0;
        m_src  = Copy_Src;
        m_dst  = Copy_Dst;
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("cmp_rs",   Rs,   m_rd(Bank_Sel, Reg_1));
      chk("cmp_rt",   Rt,   m_rd(Bank_Sel, Reg_2));
      chk("cmp_rd",   Rd,   m_rd(Bank_Sel, Reg_escrita));
      chk("cmp_rpc",  Rpc,  m_rd(Bank_Sel, 25));
      chk("cmp_rspc", Rspc, m_rd(Bank_Sel, 26));
      chk("cmp_busy", {31'b0, Copy_Busy}, {31'b0, m_copy});
      chk("cmp_done", {31'b0, Copy_Done}, {31'b0, m_done});
    end
  end

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int busy_cnt, done_cnt;
  bit seen;
  int probe [4] = '{1, 5, 24, 31};

  initial begin
    Reset = 1'b0; Reg_Write = 1'b0; Reg_escrita = '0; Reg_dados = '0;
    Reg_1 = '0; Reg_2 = '0; Counter_Halt = '0; Bank_Sel = 1'b0;
    Copy_Start = 1'b0; Copy_Src = 1'b0; Copy_Dst = 1'b0;
    c3_start = 1'b0; c3_src = '0; c3_dst = '0; c3_sel = '0;
    repeat (2) @(negedge Clock);
    #1;
    chk("rst_busy", {31'b0, Copy_Busy}, 32'h0);
    chk("rst_done", {31'b0, Copy_Done}, 32'h0);
    Reset  = 1'b1;
    chk_en = 1'b1;

    // All indices of both banks read zero after reset.
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < DEPTH; i++) begin
        Bank_Sel = b[0]; Reg_1 = i[4:0]; Reg_2 = i[4:0]; Reg_escrita = i[4:0];
        #1;
        chk("rst_rs", Rs, 32'h0);
        chk("rst_rt", Rt, 32'h0);
        chk("rst_rd", Rd, 32'h0);
      end
    end
    chk("rst_pc",  Rpc,  32'h0);
    chk("rst_spc", Rspc, 32'h0);
    chk("d3_rs",   Rs3 | Rt3 | Rd3 | Rpc3 | Rspc3, 32'h0);
    @(negedge Clock);
    #1;

    // Simple write / bank isolation.
    Bank_Sel = 1'b0; Reg_Write = 1'b1; Reg_escrita = 5'd5; Reg_dados = 32'hDEADBEEF;
    tick();
    Reg_Write = 1'b0; Reg_1 = 5'd5;
    #1 chk("wr_bank0", Rs, 32'hDEADBEEF);
    Bank_Sel = 1'b1;
    #1 chk("wr_bank1", Rs, 32'h0);
    Bank_Sel = 1'b0;

    // Halt write beats user write; register 0 stays zero.
    Counter_Halt = 32'd7; Reg_Write = 1'b1; Reg_escrita = 5'd24; Reg_dados = 32'd9;
    tick();
    Reg_Write = 1'b0; Reg_1 = 5'd24;
    #1 chk("halt_prio", Rs, 32'd7);
    Reg_Write = 1'b1; Reg_escrita = 5'd0; Reg_dados = 32'h1234;
    tick();
    Reg_Write = 1'b0; Reg_1 = 5'd0;
    #1 chk("zero_rs", Rs, 32'h0);
    chk("zero_rd", Rd, 32'h0);

    // Fill bank 0 with value = index and copy it to bank 1.
    Counter_Halt = 32'd24;
    for (int i = 1; i < DEPTH; i++) begin
      Reg_Write = 1'b1; Reg_escrita = i[4:0]; Reg_dados = i;
      tick();
    end
    Reg_Write = 1'b0;
    Copy_Src = 1'b0; Copy_Dst = 1'b1; Copy_Start = 1'b1;
    tick();
    Copy_Start = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      busy_cnt += int'(Copy_Busy);
      done_cnt += int'(Copy_Done);
      tick();
    end
    chk("copy_busy_len", busy_cnt, 32);
    chk("copy_done_cnt", done_cnt, 1);
    Bank_Sel = 1'b1;
    for (int j = 0; j < 4; j++) begin
      Reg_1 = probe[j][4:0];
      #1 chk("copy_val", Rs, probe[j]);
    end
    chk("copy_pc",  Rpc,  32'd25);
    chk("copy_spc", Rspc, 32'd26);

    // User write to bank 1 index 3 on the very edge the copy writes index 3.
    Copy_Start = 1'b1;
    tick();
    Copy_Start = 1'b0;
    repeat (3) tick();
    Reg_Write = 1'b1; Reg_escrita = 5'd3; Reg_dados = 32'h55;
    tick();
    Reg_Write = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (Copy_Done) seen = 1'b1;
      else tick();
    end
    chk("collide_done_seen", {31'b0, seen}, 32'h1);
    tick();
    Reg_1 = 5'd3;
    #1 chk("collide_user_wins", Rs, 32'h55);
    Reg_1 = 5'd4;
    #1 chk("collide_neighbour", Rs, 32'd4);

    // Copy of a bank onto itself runs full length.
    Bank_Sel = 1'b0; Copy_Src = 1'b1; Copy_Dst = 1'b1; Copy_Start = 1'b1;
    tick();
    Copy_Start = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      busy_cnt += int'(Copy_Busy);
      tick();
    end
    chk("self_copy_len", busy_cnt, 32);

    // Out-of-range source bank is ignored; a valid one starts.
    c3_start = 1'b1; c3_src = 2'd3; c3_dst = 2'd0;
    tick();
    tick();
    chk("bad_src_busy", {31'b0, Busy3}, 32'h0);
    chk("bad_src_done", {31'b0, Done3}, 32'h0);
    c3_src = 2'd2;
    tick();
    c3_start = 1'b0;
    chk("good_src_busy", {31'b0, Busy3}, 32'h1);

    // Reset in the middle of a copy (index 10).
    Copy_Src = 1'b0; Copy_Dst = 1'b1; Copy_Start = 1'b1;
    tick();
    Copy_Start = 1'b0;
    repeat (10) tick();
    chk("abort_busy_before", {31'b0, Copy_Busy}, 32'h1);
    Reset = 1'b0;
    #1 chk("abort_busy", {31'b0, Copy_Busy}, 32'h0);
    chk("abort_done", {31'b0, Copy_Done}, 32'h0);
    chk("abort_busy3", {31'b0, Busy3}, 32'h0);
    Bank_Sel = 1'b0; Reg_1 = 5'd5;
    #1 chk("abort_b0", Rs, 32'h0);
    Bank_Sel = 1'b1; Reg_1 = 5'd31;
    #1 chk("abort_b1", Rs, 32'h0);
    tick();
    tick();
    Reset = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      busy_cnt += int'(Copy_Busy);
      done_cnt += int'(Copy_Done);
      tick();
    end
    chk("post_abort_busy", busy_cnt, 0);
    chk("post_abort_done", done_cnt, 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
